// File: rtl/mul_norm_seq.sv
// Normalisation / subnormal-alignment sequencer for the FP multiplier back end.
// Shifts the raw product one bit per cycle instead of using a wide barrel shifter.
module mul_norm_seq #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 7,
    localparam int W     = 2*MANT_W + 2,
    localparam int EW    = EXPO_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EW-1:0]     expo_in,
    input  logic [W-1:0]      mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW-1:0]     expo_out,
    output logic [W-1:0]      mant_out,
    output logic              underflow,
    output logic              sticky,
    output logic              busy,
    output logic [CNT_W-1:0]  shift_cnt
);

    typedef enum logic [2:0] {IDLE, CHECK, LSHIFT, RSHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [EW-1:0]      e, e_nxt;
    logic [W-1:0]       m, m_nxt;
    logic               s, s_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               uf_nxt;
    logic               e_pos, e_one, m_zero, load_out;

    assign e_pos   = !e[EW-1] && (e != '0);
    assign e_one   = (e == EW'(1));
    assign m_zero  = (m == '0);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        e_nxt     = e;
        m_nxt     = m;
        s_nxt     = s;
        cnt_nxt   = cnt;
        uf_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    e_nxt     = expo_in;
                    m_nxt     = mant_in;
                    s_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (m_zero) begin
                    e_nxt     = '0;
                    uf_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (m[W-1] && e_pos) begin
                    e_nxt     = e + EW'(1);
                    m_nxt     = m >> 1;
                    s_nxt     = m[0];
                    state_nxt = DONE;
                end else if (!e_pos) begin
                    state_nxt = RSHIFT;
                end else if (m[W-2]) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LSHIFT;
                end
            end
            LSHIFT: begin
                if (m[W-2]) begin
                    state_nxt = DONE;
                end else if (e_one) begin
                    e_nxt     = '0;
                    uf_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    m_nxt   = m << 1;
                    e_nxt   = e - EW'(1);
                    cnt_nxt = cnt_inc;
                    // the shift that lands the leading one finishes without an extra check cycle
                    if (m[W-3]) state_nxt = DONE;
                end
            end
            RSHIFT: begin
                if (e_one || m_zero) begin
                    e_nxt     = '0;
                    uf_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    s_nxt   = s | m[0];
                    m_nxt   = m >> 1;
                    e_nxt   = e + EW'(1);
                    cnt_nxt = cnt_inc;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign load_out = (state != DONE) && (state_nxt == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            e         <= '0;
            m         <= '0;
            s         <= 1'b0;
            cnt       <= '0;
            expo_out  <= '0;
            mant_out  <= '0;
            underflow <= 1'b0;
            sticky    <= 1'b0;
        end else begin
            state <= state_nxt;
            e     <= e_nxt;
            m     <= m_nxt;
            s     <= s_nxt;
            cnt   <= cnt_nxt;
            if (load_out) begin
                expo_out  <= e_nxt;
                mant_out  <= m_nxt;
                underflow <= uf_nxt;
                sticky    <= s_nxt;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign shift_cnt = cnt;

endmodule

// File: tb/tb_mul_norm_seq.sv
// Randomised bench for mul_norm_seq against an arithmetic model of the
// normalisation rules, plus directed flush / reset / backpressure cases.
module tb_mul_norm_seq;

    localparam int W  = 48;
    localparam int EW = 10;

    logic          clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic          underflow, sticky, busy;
    logic [EW-1:0] expo_in, expo_out;
    logic [W-1:0]  mant_in, mant_out;
    logic [6:0]    shift_cnt;

    mul_norm_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .expo_in(expo_in), .mant_in(mant_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .expo_out(expo_out), .mant_out(mant_out),
        .underflow(underflow), .sticky(sticky),
        .busy(busy), .shift_cnt(shift_cnt)
    );

    typedef struct {
        logic [EW-1:0] expo;
        logic [W-1:0]  mant;
        logic          uf;
        logic          st;
        int            cnt;
        int            lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    bit   exp_ok = 0;
    exp_t cur, last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Result of normalising (e, m) derived directly from the rules, not cycle by cycle.
    function automatic exp_t model(input logic [EW-1:0] e, input logic [W-1:0] m);
        exp_t r;
        int es, msb, n, lz;
        es  = int'($signed(e));
        msb = -1;
        for (int i = 0; i < W; i++) if (m[i]) msb = i;
        r.expo = e; r.mant = m; r.uf = 1'b0; r.st = 1'b0; r.cnt = 0; r.lat = 2;
        if (m == '0) begin
            r.expo = '0;
            r.uf   = 1'b1;
        end else if (m[W-1] && es > 0) begin
            r.expo = e + EW'(1);
            r.mant = m >> 1;
            r.st   = m[0];
        end else if (es <= 0) begin
            n      = (1 - es < msb + 1) ? 1 - es : msb + 1;
            r.mant = m >> n;
            r.st   = ((r.mant << n) != m);
            r.expo = '0;
            r.uf   = 1'b1;
            r.cnt  = n;
            r.lat  = 3 + n;
        end else if (msb != W-2) begin
            lz = (W-2) - msb;
            if (lz <= es - 1) begin
                r.mant = m << lz;
                r.expo = e - EW'(lz);
                r.cnt  = lz;
                r.lat  = 2 + lz;
            end else begin
                n      = es - 1;
                r.mant = m << n;
                r.expo = '0;
                r.uf   = 1'b1;
                r.cnt  = n;
                r.lat  = 3 + n;
            end
        end
        return r;
    endfunction

    // Every cycle a result is presented, it must match the pending expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_ok) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                chk("expo_out",  64'(expo_out),  64'(cur.expo));
                chk("mant_out",  64'(mant_out),  64'(cur.mant));
                chk("underflow", 64'(underflow), 64'(cur.uf));
                chk("sticky",    64'(sticky),    64'(cur.st));
                chk("shift_cnt", 64'(shift_cnt), 64'(cur.cnt));
                chk("in_ready_while_valid", 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic run_op(input logic [EW-1:0] e, input logic [W-1:0] m, input int hold, input bit junk);
        int n;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        cur      = model(e, m);
        expo_in  = e;
        mant_in  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_ok = 1;
        if (junk) begin
            expo_in = ~e;
            mant_in = ~m;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(cur.lat));
        repeat (hold) begin
            @(negedge clk);
            chk("held_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_ok    = 0;
        out_ready = 1'b0;
        last      = cur;
        @(negedge clk);
        chk("out_valid_after_ack", 64'(out_valid), 64'(0));
        chk("idle_after_ack", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_expo_out",  64'(expo_out),  64'(0));
        chk("rst_mant_out",  64'(mant_out),  64'(0));
        chk("rst_underflow", 64'(underflow), 64'(0));
        chk("rst_sticky",    64'(sticky),    64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_shift_cnt", 64'(shift_cnt), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t     p;
        logic [63:0] r64;
        logic [W-1:0] mr;
        logic [EW-1:0] er;
        int v;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        expo_in = '0; mant_in = '0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        p = model(10'd100, 48'h8000_0000_0001);
        chk("pin1_expo", 64'(p.expo), 64'd101);
        chk("pin1_mant", 64'(p.mant), 64'h4000_0000_0000);
        chk("pin1_st",   64'(p.st),   64'd1);
        chk("pin1_lat",  64'(p.lat),  64'd2);
        p = model(10'd100, 48'h0000_4000_0000);
        chk("pin2_expo", 64'(p.expo), 64'd84);
        chk("pin2_cnt",  64'(p.cnt),  64'd16);
        p = model(10'd5, 48'h0000_4000_0000);
        chk("pin3_mant", 64'(p.mant), 64'h0004_0000_0000);
        chk("pin3_uf",   64'(p.uf),   64'd1);
        p = model(10'h3FD, 48'h4000_0000_0003);
        chk("pin4_mant", 64'(p.mant), 64'h0400_0000_0000);
        chk("pin4_st",   64'(p.st),   64'd1);
        chk("pin4_cnt",  64'(p.cnt),  64'd4);
        p = model(10'd77, 48'h0);
        chk("pin5_uf",   64'(p.uf),   64'd1);
        chk("pin5_lat",  64'(p.lat),  64'd2);

        run_op(10'd100, 48'h8000_0000_0001, 0, 0);
        run_op(10'd100, 48'h0000_4000_0000, 5, 0);
        run_op(10'd5,   48'h0000_4000_0000, 0, 1);
        run_op(10'h3FD, 48'h4000_0000_0003, 1, 0);
        run_op(10'd77,  48'h0,              0, 0);
        run_op(10'd1,   48'h0000_0000_0010, 0, 0);
        run_op(10'd0,   48'hC000_0000_0000, 2, 0);

        // flush in the middle of a left-shift run
        @(negedge clk);
        expo_in = 10'd100; mant_in = 48'h0000_4000_0000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_flush", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle",      64'(busy),     64'(0));
        chk("flush_in_ready",  64'(in_ready), 64'(1));
        chk("flush_keep_expo", 64'(expo_out), 64'(last.expo));
        chk("flush_keep_mant", 64'(mant_out), 64'(last.mant));
        repeat (25) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: er = EW'($urandom_range(1, 40));
                1: begin
                    v  = int'($urandom_range(0, 60));
                    er = EW'(-v);
                end
                default: er = EW'($urandom_range(0, 1023));
            endcase
            r64 = {$urandom(), $urandom()};
            mr  = r64[W-1:0] >> $urandom_range(0, 50);
            if ($urandom_range(0, 9) == 0) mr = '0;
            run_op(er, mr, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        // asynchronous reset during a long right-shift run
        @(negedge clk);
        expo_in = 10'h3EC; mant_in = 48'h4000_0000_0000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(10'd20, 48'h0000_0000_8001, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_norm_seq.md
Name: mul_norm_seq

Overview:
- Multi-cycle normalisation and subnormal-alignment sequencer for the FP multiplier back end.
- Accepts the raw product mantissa and biased exponent from the mantissa multiplier, and shifts one bit per cycle until the result is normalised, subnormal-aligned or zero.
- Emits exponent, mantissa, underflow and sticky to the rounding stage.
- Replaces the wide single-cycle barrel shifter in area-constrained configurations; uses a valid/ready handshake on both sides.

Parameters:
EXPO_W, 8, exponent field width; internal exponent is EXPO_W+2 bits, two's complement, MSB = negative.
MANT_W, 23, stored mantissa width; product width W = 2*MANT_W+2.
CNT_W, 7, shift counter width; must satisfy 2^CNT_W > W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns to IDLE
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input
expo_in  in  EXPO_W+2  product exponent, biased, signed
mant_in  in  W  product mantissa; bit W-2 is the integer position, bit W-1 is carry
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
expo_out  out  EXPO_W+2  result exponent; 0 for subnormal/zero
mant_out  out  W  aligned mantissa
underflow  out  1  result is subnormal or zero
sticky  out  1  OR of all bits shifted out on the right
busy  out  1  state != IDLE
shift_cnt  out  CNT_W  shifts performed for the current operation (debug)

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, expo_out=0, mant_out=0, underflow=0, sticky=0, busy=0, shift_cnt=0.
- States: IDLE, CHECK, LSHIFT, RSHIFT, DONE. Internal registers: e (exponent), m (mantissa), s (sticky), cnt.
- IDLE:
  - in_ready=1.
  - On in_valid: e=expo_in, m=mant_in, s=0, cnt=0; go to CHECK.
  - No other state accepts input.
- CHECK (one cycle), conditions evaluated in priority order:
  1. m==0: e=0, underflow=1, go to DONE.
  2. m[W-1]=1 and e>0: e=e+1, m=m>>1, s=m[0], go to DONE.
  3. e<=0 (negative or zero): go to RSHIFT.
  4. m[W-2]=1: go to DONE.
  5. Otherwise: go to LSHIFT.
- LSHIFT (one bit per cycle):
  - m[W-2]=1: go to DONE.
  - Else if e==1: e=0, underflow=1, go to DONE.
  - Else: m=m<<1, e=e-1, cnt=cnt+1.
- RSHIFT (one bit per cycle):
  - e==1 or m==0: e=0, underflow=1, go to DONE.
  - Else: s=s|m[0], m=m>>1, e=e+1, cnt=cnt+1.
  - Terminates in at most W+1 cycles; cnt saturates at 2^CNT_W-1.
- DONE:
  - out_valid=1; expo_out, mant_out, underflow, sticky and shift_cnt are registered and held stable.
  - Go to IDLE when out_ready=1. In_ready is not asserted in that same cycle (no same-cycle turnaround).
- Latency, counted from the accept edge to out_valid high:
  - 2 cycles when no shift is needed.
  - 2+N cycles for N shifts in LSHIFT or RSHIFT, plus 1 cycle for the terminating check when it ends on the e==1 or m==0 condition.
- Arithmetic: exponent add/subtract is EXPO_W+2 bits and wraps. Exponent overflow is not flagged; the rounding stage detects it.
- flush:
  - Has priority over all transitions, including DONE with out_ready.
  - Next state is IDLE and out_valid=0. Output data registers keep their last values.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- in_valid while busy is ignored; upstream must hold data until in_ready.

Test Plan:
- expo_in=100, mant_in=48'h8000_0000_0001 -> expo_out=101, mant_out=48'h4000_0000_0000, sticky=1, underflow=0, out_valid 2 cycles after accept.
- expo_in=100, mant_in=48'h0000_4000_0000 -> 16 left shifts; expo_out=84, mant_out=48'h4000_0000_0000, shift_cnt=16, underflow=0.
- expo_in=5, mant_in=48'h0000_4000_0000 -> 4 shifts then subnormal; expo_out=0, mant_out=48'h0004_0000_0000, underflow=1, sticky=0.
- expo_in=10'h3FD (-3), mant_in=48'h4000_0000_0003 -> 4 right shifts; mant_out=48'h0400_0000_0000, sticky=1, expo_out=0, underflow=1.
- mant_in=0, any expo -> expo_out=0, mant_out=0, underflow=1, sticky=0; latency 2.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
- Assert flush during LSHIFT -> IDLE next cycle, out_valid never asserted.
- Assert rst_n=0 mid-RSHIFT -> all outputs return to reset values immediately.
